// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU) with MTHI/MTLO writes.
// Define MULDIV_ABORT_EN to add the abort port, which flushes an in-flight operation.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic                 div0_q, div0_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 abort_w;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;

`ifdef MULDIV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // prod_q holds {upper/remainder, lower/quotient}; both algorithms shift the same register
    assign mul_addend = prod_q[0] ? mcand_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign div_shift  = prod_q[2*WIDTH-1:WIDTH-1];
    assign div_diff   = div_shift - {1'b0, mcand_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (abort_w)                         state_d = S_IDLE;
                else if (cnt_q == CW'(WIDTH - 1))    state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    always_comb begin
        logic             rs_neg, rt_neg;
        logic [2*WIDTH-1:0] prod_res;
        logic [WIDTH-1:0] quo, rem;
        op_d     = op_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rs_neg   = ~op[0] & rs_val[WIDTH-1];
        rt_neg   = ~op[0] & rt_val[WIDTH-1];
        prod_res = qsign_q ? -prod_q : prod_q;
        quo      = prod_q[WIDTH-1:0];
        rem      = prod_q[2*WIDTH-1:WIDTH];
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_d    = op;
                    mcand_d = rt_neg ? -rt_val : rt_val;
                    prod_d  = {{WIDTH{1'b0}}, (rs_neg ? -rs_val : rs_val)};
                    qsign_d = rs_neg ^ rt_neg;
                    rsign_d = rs_neg;
                    div0_d  = op[1] & (rt_val == '0);
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (!abort_w) begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[1]) begin
                        if (!div_diff[WIDTH])
                            prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                        else
                            prod_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
                    end else begin
                        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                    end
                end
            end
            S_FIX: begin
                if (!abort_w) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        // zero divisor leaves quotient all ones; skip the sign fix so LO stays all ones
                        lo_d = div0_q ? {WIDTH{1'b1}} : (qsign_q ? -quo : quo);
                        hi_d = rsign_q ? -rem : rem;
                    end else begin
                        hi_d = prod_res[2*WIDTH-1:WIDTH];
                        lo_d = prod_res[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
